nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Multi-precision adder sequencer. Adds two WIDTH-bit operands by reusing one internal 4-bit ripple-carry adder (bit4_4fullAdders) once per nibble, LSB nibble first. The carry is kept in a register between cycles. Valid/ready handshake on input and output. Lets the datapath do 8/16/32-bit adds at the cost of one 4-bit adder plus registers.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
NIBBLES, WIDTH/4, derived (localparam); number of adder passes per operation.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  reset.
in_valid  input  1  a, b, c_in present a request.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry into nibble 0.
out_valid  output  1  sum/c_out hold a completed result.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, a+b+c_in modulo 2^WIDTH.
c_out  output  1  carry out of the top nibble (bit WIDTH of a+b+c_in).

Interface (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- FSM states: IDLE, ADD, HOLD. All outputs are registered or decoded from the state register only; no combinational input-to-output paths.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, nibble counter=0, carry reg=0, operand shift regs=0, sum=0, c_out=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset in any state aborts the operation; no partial result is ever presented.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b into shift regs and c_in into the carry reg; counter=0; go to ADD.
  - No transfer without in_valid.
- ADD:
  - in_ready=0, out_valid=0.
  - Each cycle, the adder gets a_sh[3:0], b_sh[3:0] and the carry reg.
  - On the edge: a_sh and b_sh shift right by 4; the adder's 4-bit sum enters sum_sh from the top (sum_sh <= {nib_sum, sum_sh[WIDTH-1:4]}); carry reg <= adder carry-out; counter++.
  - When counter==NIBBLES-1 on the edge: sum <= final sum_sh value, c_out <= final carry, state becomes HOLD.
- Latency: request accepted at edge k; out_valid=1 after edge k+NIBBLES. For WIDTH=4 this is 1 cycle.
- HOLD:
  - out_valid=1, in_ready=0.
  - sum and c_out stay stable while out_ready=0, for any duration.
  - On out_valid&&out_ready: go to IDLE; out_valid=0 the next cycle. The next request can be accepted one cycle after the result is taken (no same-cycle overlap).
- in_valid and any operand change while in_ready=0 are ignored. Operands do not need to be held after acceptance.
- sum and c_out keep the last result after it is consumed; they are only meaningful while out_valid=1.
- Arithmetic:
  - Unsigned; wrap-around modulo 2^WIDTH; c_out is the overflow bit.
  - All-ones + 0 with c_in=1 ripples the carry through every nibble across cycles.
  - Signed overflow is not reported.
- Counter width is clog2(NIBBLES), minimum 1. The counter never exceeds NIBBLES-1.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x4321, c_in=0, accept at edge k -> out_valid high after edge k+4; sum=0x5555, c_out=0; in_ready=0 for the 4 ADD cycles and while in HOLD.
2. WIDTH=16: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Repeat with a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1 (carry crosses all 4 nibble boundaries).
3. Backpressure, WIDTH=16: result 0x00F0+0x0F10=0x1000, c_out=0; hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands -> sum, c_out, out_valid stable, in_ready=0, new request not taken. Raise out_ready -> out_valid=0 next cycle, then in_ready=1 and the pending request is accepted.
4. Reset mid-op, WIDTH=16: accept 0xAAAA+0x5555, assert rst_n=0 after 2 ADD cycles -> next cycle sum=0, c_out=0, out_valid=0, in_ready=1. A fresh request 0x0001+0x0001 then yields 0x0002, c_out=0.
5. WIDTH=4: a=0x9, b=0x8, c_in=1 -> out_valid one edge after accept; sum=0x2, c_out=1.
6. WIDTH=32: 1000 random a, b, c_in with random out_ready stalls -> every {c_out,sum} equals a+b+c_in as a 33-bit value; latency is exactly 8 cycles; no result lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision serial adder: one 4-bit ripple adder reused once per nibble,
// LSB nibble first, with the carry held in a register between passes.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// ADD   | one nibble added per cycle, carry kept in carry_q
// HOLD  | result presented on sum/c_out, waiting for out_ready

module bit4_4fullAdders (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic c1, c2, c3;

   assign s[0] = a[0] ^ b[0] ^ ci;
   assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
   assign s[1] = a[1] ^ b[1] ^ c1;
   assign c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
   assign s[2] = a[2] ^ b[2] ^ c2;
   assign c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
   assign s[3] = a[3] ^ b[3] ^ c3;
   assign co   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ADD, HOLD} state_e;

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] a_sh_q,      a_sh_d;
   logic [WIDTH-1:0] b_sh_q,      b_sh_d;
   logic [WIDTH-1:0] sum_sh_q,    sum_sh_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             carry_q,     carry_d;
   logic             c_out_q,     c_out_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic [3:0]       nib_sum;
   logic             nib_co;
   logic [WIDTH-1:0] nib_top;

   bit4_4fullAdders u_add (
      .a  (a_sh_q[3:0]),
      .b  (b_sh_q[3:0]),
      .ci (carry_q),
      .s  (nib_sum),
      .co (nib_co)
   );

   // nibble result placed at the top of the word, so it can enter sum_sh from above
   assign nib_top = WIDTH'(nib_sum) << (WIDTH - 4);

   // next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_sh_d    = sum_sh_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      c_out_d     = c_out_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d     = a;
               b_sh_d     = b;
               carry_d    = c_in;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = ADD;
            end
         end
         ADD: begin
            a_sh_d   = a_sh_q >> 4;
            b_sh_d   = b_sh_q >> 4;
            sum_sh_d = nib_top | (sum_sh_q >> 4);
            carry_d  = nib_co;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_NIB) begin
               // counter parks at 0 so it never exceeds the last nibble index
               cnt_d       = '0;
               sum_d       = sum_sh_d;
               c_out_d     = nib_co;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_sh_q    <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_sh_q    <= sum_sh_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         c_out_q     <= c_out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at WIDTH=16, 4 and 32. Expected results
// come from plain wide addition a+b+c_in; expected latency is WIDTH/4 cycles.

module tb_nibble_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv16 = 0, ir16, ov16, or16 = 0, ci16 = 0, co16;
   logic [15:0] a16 = 0, b16 = 0, s16;
   logic        iv4 = 0, ir4, ov4, or4 = 0, ci4 = 0, co4;
   logic [3:0]  a4 = 0, b4 = 0, s4;
   logic        iv32 = 0, ir32, ov32, or32 = 0, ci32 = 0, co32;
   logic [31:0] a32 = 0, b32 = 0, s32;

   int n_cmp = 0;
   int n_err = 0;

   nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .c_in(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16));
   nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .c_in(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(co4));
   nibble_serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .c_in(ci32), .out_valid(ov32), .out_ready(or32), .sum(s32), .c_out(co32));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // stimulus helper: one full 16-bit transaction, returns what was observed
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output logic [15:0] s, output logic co, output int lat,
                       output bit busy_ok);
      int t = 0;
      while (!ir16 && t < 20) begin cyc(); t++; end
      a16 = a; b16 = b; ci16 = ci; iv16 = 1;
      cyc();
      iv16 = 0;
      lat = 0;
      busy_ok = 1;
      while (!ov16 && lat < 40) begin
         if (ir16) busy_ok = 0;
         cyc();
         lat++;
      end
      if (ir16) busy_ok = 0;
      s = s16; co = co16;
      or16 = 1;
      cyc();
      or16 = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      cyc(); cyc();
      n_cmp++; if ({ir16, ov16, s16, co16} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
         n_err++; $display("FAIL reset16 got ir=%b ov=%b sum=%h co=%b want 1 0 0000 0", ir16, ov16, s16, co16); end
      n_cmp++; if ({ir4, ov4, s4, co4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
         n_err++; $display("FAIL reset4 got ir=%b ov=%b sum=%h co=%b want 1 0 0 0", ir4, ov4, s4, co4); end
      n_cmp++; if ({ir32, ov32, s32, co32} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         n_err++; $display("FAIL reset32 got ir=%b ov=%b sum=%h co=%b want 1 0 0 0", ir32, ov32, s32, co32); end
      rst_n = 1;
      cyc(); cyc();
      n_cmp++; if ({ir16, ov16} !== 2'b10) begin
         n_err++; $display("FAIL idle_no_transfer got ir=%b ov=%b want 1 0", ir16, ov16); end
   endtask

   task automatic test_basic();
      logic [15:0] s; logic co; int lat; bit ok;
      op16(16'h1234, 16'h4321, 1'b0, s, co, lat, ok);
      n_cmp++; if ({co, s} !== 17'h05555) begin
         n_err++; $display("FAIL basic_sum got %b_%h want 0_5555", co, s); end
      n_cmp++; if (lat !== 4) begin
         n_err++; $display("FAIL basic_latency got %0d want 4", lat); end
      n_cmp++; if (ok !== 1'b1) begin
         n_err++; $display("FAIL basic_in_ready_busy got in_ready high while busy want low"); end
      n_cmp++; if (ov16 !== 1'b0) begin
         n_err++; $display("FAIL basic_take got ov=%b want 0", ov16); end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] s; logic co; int lat; bit ok;
      logic [16:0] exp;
      op16(16'hFFFF, 16'h0001, 1'b0, s, co, lat, ok);
      exp = 17'(16'hFFFF) + 17'(16'h0001);
      n_cmp++; if ({co, s} !== exp) begin
         n_err++; $display("FAIL ripple1 got %b_%h want %b_%h", co, s, exp[16], exp[15:0]); end
      op16(16'hFFFF, 16'h0000, 1'b1, s, co, lat, ok);
      exp = 17'(16'hFFFF) + 17'(1);
      n_cmp++; if ({co, s} !== exp) begin
         n_err++; $display("FAIL ripple_cin got %b_%h want %b_%h", co, s, exp[16], exp[15:0]); end
      n_cmp++; if (lat !== 4) begin
         n_err++; $display("FAIL ripple_latency got %0d want 4", lat); end
   endtask

   task automatic test_backpressure();
      int t;
      a16 = 16'h00F0; b16 = 16'h0F10; ci16 = 0; iv16 = 1;
      cyc();
      a16 = 16'h1111; b16 = 16'h2222; ci16 = 1;
      t = 0;
      while (!ov16 && t < 40) begin cyc(); t++; end
      n_cmp++; if (t !== 4) begin
         n_err++; $display("FAIL bp_latency got %0d want 4", t); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({ov16, ir16, co16, s16} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
            n_err++; $display("FAIL bp_hold[%0d] got ov=%b ir=%b co=%b sum=%h want 1 0 0 1000", i, ov16, ir16, co16, s16); end
         cyc();
      end
      or16 = 1;
      cyc();
      or16 = 0;
      n_cmp++; if ({ov16, ir16} !== 2'b01) begin
         n_err++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", ov16, ir16); end
      cyc();
      iv16 = 0;
      n_cmp++; if (ir16 !== 1'b0) begin
         n_err++; $display("FAIL bp_pending_accept got ir=%b want 0", ir16); end
      t = 0;
      while (!ov16 && t < 40) begin cyc(); t++; end
      n_cmp++; if ({co16, s16} !== 17'(16'h1111) + 17'(16'h2222) + 17'd1) begin
         n_err++; $display("FAIL bp_pending_sum got %b_%h want 0_3334", co16, s16); end
      or16 = 1;
      cyc();
      or16 = 0;
   endtask

   task automatic test_reset_midop();
      logic [15:0] s; logic co; int lat; bit ok;
      a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 0; iv16 = 1;
      cyc();
      iv16 = 0;
      cyc(); cyc();
      rst_n = 0;
      cyc();
      rst_n = 1;
      n_cmp++; if ({s16, co16, ov16, ir16} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL midop_reset got sum=%h co=%b ov=%b ir=%b want 0000 0 0 1", s16, co16, ov16, ir16); end
      for (int i = 0; i < 6; i++) begin
         if (ov16) begin
            n_cmp++; n_err++; $display("FAIL midop_partial got ov=1 want 0");
         end
         cyc();
      end
      op16(16'h0001, 16'h0001, 1'b0, s, co, lat, ok);
      n_cmp++; if ({co, s} !== 17'h00002) begin
         n_err++; $display("FAIL midop_fresh got %b_%h want 0_0002", co, s); end
      n_cmp++; if (lat !== 4) begin
         n_err++; $display("FAIL midop_latency got %0d want 4", lat); end
   endtask

   task automatic test_width4();
      logic [4:0] exp;
      a4 = 4'h9; b4 = 4'h8; ci4 = 1; iv4 = 1;
      cyc();
      iv4 = 0;
      n_cmp++; if ({ov4, ir4} !== 2'b00) begin
         n_err++; $display("FAIL w4_busy got ov=%b ir=%b want 0 0", ov4, ir4); end
      cyc();
      exp = 5'(4'h9) + 5'(4'h8) + 5'd1;
      n_cmp++; if ({ov4, co4, s4} !== {1'b1, exp}) begin
         n_err++; $display("FAIL w4_result got ov=%b co=%b sum=%h want 1 %b %h", ov4, co4, s4, exp[4], exp[3:0]); end
      or4 = 1;
      cyc();
      or4 = 0;
      n_cmp++; if ({ov4, ir4} !== 2'b01) begin
         n_err++; $display("FAIL w4_take got ov=%b ir=%b want 0 1", ov4, ir4); end
   endtask

   task automatic test_random32();
      logic [31:0] ra, rb; logic rc;
      logic [32:0] exp;
      int t, lat, stall, n_res;
      n_res = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
         if (n % 50 == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1; end
         exp = 33'(ra) + 33'(rb) + 33'(rc);
         for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
         t = 0;
         while (!ir32 && t < 20) begin cyc(); t++; end
         a32 = ra; b32 = rb; ci32 = rc; iv32 = 1;
         cyc();
         lat = 0;
         while (!ov32 && lat < 40) begin
            iv32 = 1'($urandom); a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
            cyc();
            lat++;
         end
         n_cmp++; if (lat !== 8) begin
            n_err++; $display("FAIL rand_latency[%0d] got %0d want 8", n, lat); end
         stall = $urandom_range(0, 3);
         for (int k = 0; k < stall; k++) begin
            iv32 = 1'($urandom); a32 = $urandom;
            cyc();
         end
         n_cmp++; if ({ov32, co32, s32} !== {1'b1, exp}) begin
            n_err++; $display("FAIL rand_sum[%0d] got ov=%b %b_%h want 1 %b_%h", n, ov32, co32, s32, exp[32], exp[31:0]); end
         if (ov32) n_res++;
         or32 = 1; iv32 = 0;
         cyc();
         or32 = 0;
         if (ov32) begin
            n_cmp++; n_err++; $display("FAIL rand_dup[%0d] got ov=1 after take want 0", n);
         end
      end
      n_cmp++; if (n_res !== 1000) begin
         n_err++; $display("FAIL rand_count got %0d want 1000", n_res); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_backpressure();
      test_reset_midop();
      test_width4();
      test_random32();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
